bcd_stopwatch_counter: RTL and testbench

Parametrised BCD stopwatch counter that replaces the fixed 8-digit free-running counter. It counts rising edges of a slow tick, sampled and edge-detected in the `clk` domain. Digits wrap per stopwatch convention (mod-10 or mod-6 per digit). It adds start/stop/clear control, a lap-capture register, and an overflow pulse. It feeds the display multiplexer with packed BCD.

---
 rtl/bcd_stopwatch_counter.sv | 91 +++++++++
 tb/tb_bcd_stopwatch_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_counter.sv
// BCD stopwatch counter: start/stop/clear control, lap capture and overflow pulse.
// Define BCD_STOPWATCH_LAP_EN to build the lap register; otherwise lap_data mirrors data.
module bcd_stopwatch_counter #(
    parameter int unsigned       DIGITS    = 8,
    parameter logic [DIGITS-1:0] MOD6_MASK = DIGITS'('h28)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   lap_data,
    output logic                  running,
    output logic                  overflow
);

    logic                s0;
    logic                s1;
    logic                prev;
    logic                inc;
    logic [DIGITS-1:0]   at_max;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] data_inc;

    assign inc = s1 & ~prev & running;

    // Carry into digit g is inc AND'ed with every lower digit sitting at its max.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign at_max[g] = (data[4*g +: 4] == (MOD6_MASK[g] ? 4'd5 : 4'd9));
        if (g == 0) begin : g_first
            assign carry[g] = inc;
        end else begin : g_rest
            assign carry[g] = inc & (&at_max[g-1:0]);
        end
        assign data_inc[4*g +: 4] = !carry[g] ? data[4*g +: 4] :
                                    at_max[g] ? 4'd0 : data[4*g +: 4] + 4'd1;
    end

    assign carry[DIGITS] = inc & (&at_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            s0       <= 1'b0;
            s1       <= 1'b0;
            prev     <= 1'b0;
            running  <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            s0   <= tick;
            s1   <= s0;
            prev <= s1;
            if (stop) begin
                running <= 1'b0;
            end else if (start) begin
                running <= 1'b1;
            end
            // Clear drops a coincident increment, including its overflow.
            if (clear) begin
                data     <= '0;
                overflow <= 1'b0;
            end else begin
                data     <= data_inc;
                overflow <= carry[DIGITS];
            end
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic [4*DIGITS-1:0] lap_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_reg <= '0;
        end else if (lap) begin
            lap_reg <= data;
        end
    end

    assign lap_data = lap_reg;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign lap_data   = data;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Randomized bench for bcd_stopwatch_counter: an 8-digit default instance and a 2-digit
// all-decimal instance share clk/reset/tick and are checked against a mixed-radix tick-count model.
module tb_bcd_stopwatch_counter;

    localparam logic [15:0] MASK8 = 16'h0028;
    localparam logic [15:0] MASK2 = 16'h0000;

    logic        clk = 1'b0;
    logic        reset, tick;
    logic        start8, stop8, clear8, lap8, start2, stop2, clear2;
    logic [31:0] data8, lap_data8;
    logic        running8, overflow8;
    logic [7:0]  data2, lap_data2;
    logic        running2, overflow2;

    always #5 clk = ~clk;

    bcd_stopwatch_counter dut8 (
        .clk(clk), .reset(reset), .tick(tick), .start(start8), .stop(stop8),
        .clear(clear8), .lap(lap8), .data(data8), .lap_data(lap_data8),
        .running(running8), .overflow(overflow8)
    );

    bcd_stopwatch_counter #(.DIGITS(2), .MOD6_MASK(2'b00)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .start(start2), .stop(stop2),
        .clear(clear2), .lap(1'b0), .data(data2), .lap_data(lap_data2),
        .running(running2), .overflow(overflow2)
    );

    int total = 0;
    int bad   = 0;

    // Model: each counter is a plain tick count; digits are its mixed-radix expansion.
    longint n8, n2, lap_exp, cap8, cap2;
    bit     run8, run2;
    int     ov8_exp = 0, ov2_exp = 0, ov8_seen = 0, ov2_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint capacity(input int nd, input logic [15:0] mask);
        longint c = 1;
        for (int i = 0; i < nd; i++) c = c * (mask[i] ? 6 : 10);
        return c;
    endfunction

    function automatic logic [63:0] to_bcd(input longint n, input int nd, input logic [15:0] mask);
        logic [63:0] r = '0;
        longint      v = n;
        longint      m;
        for (int i = 0; i < nd; i++) begin
            m = mask[i] ? 6 : 10;
            r[4*i +: 4] = 4'(v % m);
            v = v / m;
        end
        return r;
    endfunction

    task automatic bump(inout longint n, input longint cap, inout int ov);
        n = n + 1;
        if (n == cap) begin
            n = 0;
            ov++;
        end
    endtask

    always @(negedge clk) begin
        ov8_seen += int'(overflow8);
        ov2_seen += int'(overflow2);
    end

`ifndef BCD_STOPWATCH_LAP_EN
    always @(negedge clk) check("lap_passthru", lap_data8, data8);
`endif

    task automatic check_all(input string tag);
        check({tag, "/data8"}, data8, to_bcd(n8, 8, MASK8));
        check({tag, "/run8"}, running8, run8);
        check({tag, "/ov8"}, ov8_seen, ov8_exp);
        check({tag, "/data2"}, data2, to_bcd(n2, 2, MASK2));
        check({tag, "/run2"}, running2, run2);
        check({tag, "/ov2"}, ov2_seen, ov2_exp);
`ifdef BCD_STOPWATCH_LAP_EN
        check({tag, "/lap8"}, lap_data8, to_bcd(lap_exp, 8, MASK8));
`endif
    endtask

    task automatic tick_once();
        int h, l;
        h = $urandom_range(2, 3);
        l = $urandom_range(2, 3);
        tick = 1'b1;
        repeat (h) @(negedge clk);
        tick = 1'b0;
        repeat (l) @(negedge clk);
        if (run8) bump(n8, cap8, ov8_exp);
        if (run2) bump(n2, cap2, ov2_exp);
    endtask

    task automatic pulse(input bit st8, input bit sp8, input bit cl8, input bit lp8,
                         input bit st2, input bit sp2, input bit cl2);
        start8 = st8; stop8 = sp8; clear8 = cl8; lap8 = lp8;
        start2 = st2; stop2 = sp2; clear2 = cl2;
        @(negedge clk);
        {start8, stop8, clear8, lap8, start2, stop2, clear2} = '0;
        if (lp8) lap_exp = n8;
        if (cl8) n8 = 0;
        if (sp8) run8 = 0; else if (st8) run8 = 1;
        if (cl2) n2 = 0;
        if (sp2) run2 = 0; else if (st2) run2 = 1;
    endtask

    // Controls land on the same clk edge that registers the detected tick edge.
    task automatic tick_coinc(input bit st8, input bit sp8, input bit cl8, input bit lp8,
                              input bit cl2);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        start8 = st8; stop8 = sp8; clear8 = cl8; lap8 = lp8; clear2 = cl2;
        @(negedge clk);
        {start8, stop8, clear8, lap8, clear2} = '0;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        if (lp8) lap_exp = n8;
        if (cl8) n8 = 0; else if (run8) bump(n8, cap8, ov8_exp);
        if (sp8) run8 = 0; else if (st8) run8 = 1;
        if (cl2) n2 = 0; else if (run2) bump(n2, cap2, ov2_exp);
    endtask

    initial begin
        cap8 = capacity(8, MASK8);
        cap2 = capacity(2, MASK2);
        reset = 1'b1;
        tick  = 1'b0;
        {start8, stop8, clear8, lap8, start2, stop2, clear2} = '0;
        n8 = 0; n2 = 0; lap_exp = 0; run8 = 0; run2 = 0;
        repeat (3) @(negedge clk);
        check("rst/data8", data8, 32'h0);
        check("rst/lap8", lap_data8, 32'h0);
        check("rst/run8", running8, 1'b0);
        check("rst/ov8", overflow8, 1'b0);
        check("rst/data2", data2, 8'h0);
        reset = 1'b0;
        @(negedge clk);

        // Two-digit wrap and clear-vs-overflow.
        pulse(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 99; i++) tick_once();
        check("d2/at99", data2, 8'h99);
        tick_once();
        check("d2/wrap", data2, 8'h00);
        check("d2/ov_once", ov2_seen, 1);
        check_all("d2wrap");
        for (int i = 0; i < 99; i++) tick_once();
        tick_coinc(0, 0, 0, 0, 1);
        check("d2/clr_data", data2, 8'h00);
        check("d2/clr_noov", ov2_seen, 1);
        check_all("d2clr");
        pulse(0, 0, 0, 0, 0, 1, 0);

        // 150 counts.
        pulse(1, 0, 0, 0, 0, 0, 0);
        check("start/run8", running8, 1'b1);
        for (int i = 0; i < 150; i++) begin
            tick_once();
            check_all("c150");
        end
        check("c150/data8", data8, 32'h0000_0150);
        check("c150/noov", ov8_seen, 0);

        // Stop/start gating.
        pulse(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 42; i++) tick_once();
        pulse(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick_once();
        check("stop/held", data8, 32'h0000_0042);
        pulse(1, 1, 0, 0, 0, 0, 0);
        check("startstop/run8", running8, 1'b0);
        pulse(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick_once();
        check("restart/data8", data8, 32'h0000_0045);
        check_all("ss");

        // Lap coincident with an increment.
        for (int i = 0; i < 32; i++) tick_once();
        tick_coinc(0, 0, 0, 1, 0);
        check("lap/data8", data8, 32'h0000_0078);
`ifdef BCD_STOPWATCH_LAP_EN
        check("lap/lap8", lap_data8, 32'h0000_0077);
`endif
        check_all("lap");

        // Reset mid-count with tick held high.
        for (int i = 0; i < 1234 - 78; i++) tick_once();
        check("pre_rst/data8", data8, 32'h0000_1234);
        tick = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst/data8", data8, 32'h0);
        check("mid_rst/lap8", lap_data8, 32'h0);
        check("mid_rst/run8", running8, 1'b0);
        check("mid_rst/ov8", overflow8, 1'b0);
        reset = 1'b0;
        n8 = 0; n2 = 0; lap_exp = 0; run8 = 0; run2 = 0;
        repeat (5) @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst/held", data8, 32'h0);
        pulse(1, 0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        check("post_rst/no_edge", data8, 32'h0);
        tick_once();
        check("post_rst/first", data8, 32'h0000_0001);

        // Mod-6 wrap on d3 and carry into d4.
        for (int i = 0; i < 5998; i++) begin
            tick_once();
            check_all("bulk");
        end
        check("m6/at5999", data8, 32'h0000_5999);
        tick_once();
        check("m6/carry", data8, 32'h0001_0000);
        check_all("m6");

        // Random mix of ticks, control pulses and coincident controls.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                tick_once();
            end else if (r < 8) begin
                pulse($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
                      $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 5) == 0);
            end else begin
                tick_coinc($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
                           $urandom_range(0, 5) == 0);
            end
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
